// File: rtl/rca_seq_pkg.sv
// Shared types and elaboration helpers for the sequential ripple-carry adder.
package rca_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_DWIDTH = 8;
   localparam int DEF_CHUNK  = 2;
   localparam int ERR_CNT_W  = 16;

   // Chunk index width; a single-chunk build still needs a 1-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // CHUNK must divide DWIDTH and lie in 1..DWIDTH.
   function automatic bit params_ok(input int dw, input int ch);
      return (ch >= 1) && (ch <= dw) && ((dw % ch) == 0);
   endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder made of full-adder bit cells.
module rca_chunk #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W:0] c;

   // Ripple the carry through one full-adder cell per bit.
   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[W];
   end

endmodule

// File: rtl/rca_seq_adder.sv
// Sequential ripple-carry adder: operands accepted over a valid/ready channel,
// summed CHUNK bits per cycle, result returned over a valid/ready channel.
// Optional build macro RCA_SEQ_CHK_EN adds a reference-adder self check and
// the err_cnt output.
module rca_seq_adder
   import rca_seq_pkg::*;
#(
   parameter int DWIDTH = DEF_DWIDTH,
   parameter int CHUNK  = DEF_CHUNK
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_a,
   input  logic [DWIDTH-1:0] in_b,
   input  logic              in_cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_s,
   output logic              out_cout,
   output logic              busy
`ifdef RCA_SEQ_CHK_EN
   ,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   localparam int NCHUNK = DWIDTH / CHUNK;
   localparam int IW     = idx_w(NCHUNK);

   if (!params_ok(DWIDTH, CHUNK)) begin : g_param_err
      $error("rca_seq_adder: CHUNK must divide DWIDTH and be in 1..DWIDTH");
   end

   state_e            state_q;
   logic [IW-1:0]     idx_q;
   logic [DWIDTH-1:0] a_q, b_q, sum_q, sum_d;
   logic              carry_q;
   logic              in_ready_q, out_valid_q, out_cout_q, busy_q;
   logic [DWIDTH-1:0] out_s_q;

   logic [CHUNK-1:0]  a_sl, b_sl, s_sl;
   logic              c_sl;
   logic              last_chunk;
   logic              accept;

   assign a_sl       = a_q[idx_q*CHUNK +: CHUNK];
   assign b_sl       = b_q[idx_q*CHUNK +: CHUNK];
   assign last_chunk = (idx_q == IW'(NCHUNK - 1));
   assign accept     = (state_q == IDLE) && in_valid && in_ready_q;

   rca_chunk #(.W(CHUNK)) u_chunk (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry_q),
      .s    (s_sl),
      .cout (c_sl)
   );

   // Merge the freshly computed slice into the running result.
   always_comb begin
      sum_d = sum_q;
      sum_d[idx_q*CHUNK +: CHUNK] = s_sl;
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_s_q     <= '0;
         out_cout_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
               if (accept) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  carry_q    <= in_cin;
                  sum_q      <= '0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               sum_q   <= sum_d;
               carry_q <= c_sl;
               idx_q   <= idx_q + 1'b1;
               if (last_chunk) begin
                  out_s_q     <= sum_d;
                  out_cout_q  <= c_sl;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_s     = out_s_q;
   assign out_cout  = out_cout_q;
   assign busy      = busy_q;

`ifdef RCA_SEQ_CHK_EN
   logic                 cin0_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic [DWIDTH:0]      ref_sum;
   logic                 chk_mismatch;

   assign ref_sum      = {1'b0, a_q} + {1'b0, b_q} + {{DWIDTH{1'b0}}, cin0_q};
   assign chk_mismatch = (state_q == CALC) && last_chunk && ({c_sl, sum_d} != ref_sum);

   // Keep the original carry-in and count saturating reference mismatches.
   always_ff @(posedge clk) begin
      if (rst) begin
         cin0_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         if (accept) begin
            cin0_q <= in_cin;
         end
         if (chk_mismatch && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
         end
      end
   end

   // Flag every completion that disagrees with the reference adder.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!chk_mismatch);
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rca_seq_adder.sv
// Self-checking bench for rca_seq_adder with a queue-based arithmetic model.
module tb_rca_seq_adder;

   localparam int DW     = 8;
   localparam int NCHUNK = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_cin;
   logic [DW-1:0] in_a, in_b;
   logic          out_valid, out_ready, out_cout, busy;
   logic [DW-1:0] out_s;
`ifdef RCA_SEQ_CHK_EN
   logic [15:0]   err_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   rca_seq_adder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_cout  (out_cout),
      .busy      (busy)
`ifdef RCA_SEQ_CHK_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait for in_ready, present one operand pair for exactly one accepting edge.
   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
      int w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check("in_ready_before_send", in_ready, 1);
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = DW'($urandom); in_b = DW'($urandom); in_cin = 1'($urandom);
      exp_q.push_back(int'(a) + int'(b) + int'(c));
   endtask

   // Measure latency from the accepting edge, hold backpressure, then handshake.
   task automatic collect(input int hold, input string tag);
      int lat = 0;
      int e;
      do begin
         @(posedge clk); #1;
         lat++;
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
      end while (!out_valid && lat < 20);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      e = exp_q.pop_front();
      check({tag, "_latency"}, lat, NCHUNK);
      check({tag, "_sum"}, out_s, e & 8'hFF);
      check({tag, "_cout"}, out_cout, (e >> 8) & 1);
      check({tag, "_busy_done"}, busy, 1);
      check({tag, "_in_ready_done"}, in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_sum"}, {out_cout, out_s}, e & 9'h1FF);
         check({tag, "_hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_busy_idle"}, busy, 0);
      check({tag, "_in_ready_idle"}, in_ready, 1);
      check({tag, "_retain"}, {out_cout, out_s}, e & 9'h1FF);
   endtask

   initial begin
      int seen;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out", {out_cout, out_s}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_in_ready", in_ready, 1);

      send(8'h5A, 8'h33, 1'b0); collect(0, "t1");
      send(8'hFF, 8'h01, 1'b0); collect(1, "t2");
      send(8'hFF, 8'hFF, 1'b1); collect(0, "t3a");
      send(8'h00, 8'h00, 1'b0); collect(2, "t3b");
      send(8'h10, 8'h20, 1'b0); collect(5, "t4");
      send(8'hC3, 8'h3C, 1'b1); collect(0, "t4_next");

      // Reset two cycles into CALC aborts the transaction.
      send(8'hAA, 8'h55, 1'b1);
      void'(exp_q.pop_front());
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_out", {out_valid, out_cout, out_s}, 0);
      @(posedge clk); #1;
      check("abort_in_ready_after", in_ready, 1);
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid || busy) seen++;
      end
      check("abort_no_result", seen, 0);
      send(8'h7E, 8'h81, 1'b1); collect(1, "t5");

      for (int n = 0; n < 1000; n++) begin
         send(DW'($urandom), DW'($urandom), 1'($urandom));
         collect(int'($urandom_range(0, 3)), "rand");
      end

`ifdef RCA_SEQ_CHK_EN
      check("err_cnt", err_cnt, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
